uart_tx_buf: RTL and testbench
==============================

UART_TX_BUF -- requirements
Module: uart_tx_buf

Interface
REQ-001 SHALL take clock clk and reset reset, synchronous, active-high.
REQ-002 SHALL have parameter CLK_DIV, default 10416, clocks per bit period (>=2).
REQ-003 SHALL have parameter DATA_BITS, default 8, data bits per frame (5..8).
REQ-004 SHALL have parameter STOP_BITS, default 1, stop bits per frame (1 or 2).
REQ-005 SHALL have parameter FIFO_DEPTH, default 8, TX buffer entries (power of 2, >=2).
REQ-006 SHALL have parameter PARITY_ODD, default 0, parity sense (0 even, 1 odd); used only with UART_TX_PARITY_EN.
REQ-007 Ports:
  clk  in  1  clock
  reset  in  1  sync active-high reset
  in_valid  in  1  write request
  in_data  in  8  byte; bits above DATA_BITS-1 ignored
  in_ready  out  1  buffer not full
  TxD  out  1  serial line, idle high
  busy  out  1  frame in progress or buffer non-empty
  tx_done  out  1  one-cycle pulse at end of each frame
  fifo_count  out  $clog2(FIFO_DEPTH)+1  entries held

Function
REQ-008 Write SHALL occur on edge where in_valid && in_ready; in_ready = (fifo_count != FIFO_DEPTH), combinational from count only.
REQ-009 Write while full SHALL be dropped; no state change; simultaneous pop does not enable it that cycle.
REQ-010 FSM states IDLE, START, DATA, PARITY, STOP; PARITY visited only with UART_TX_PARITY_EN.
REQ-011 IDLE: TxD=1; if buffer non-empty, pop head, load shifter, go START, TxD<=0 on same edge.
REQ-012 Each START/DATA/PARITY/STOP bit SHALL hold TxD exactly CLK_DIV cycles, counted by baud counter reset at each state entry.
REQ-013 DATA: LSB first, DATA_BITS bits, then PARITY or STOP.
REQ-014 STOP: TxD=1 for STOP_BITS*CLK_DIV cycles; at last cycle assert tx_done for one cycle.
REQ-015 End of STOP with buffer non-empty SHALL pop and enter START on same edge (no idle gap); else IDLE.
REQ-016 Latency: write at edge N into empty buffer in IDLE -> TxD low after edge N+1.
REQ-017 Write and pop on same edge SHALL leave fifo_count unchanged and both take effect.
REQ-018 Counters SHALL wrap internal pointers modulo FIFO_DEPTH; fifo_count never exceeds FIFO_DEPTH or goes below 0.
REQ-019 busy = (state != IDLE) || (fifo_count != 0).

Reset
REQ-020 On reset: state IDLE, TxD=1, tx_done=0, fifo_count=0, in_ready=1, busy=0, baud/bit counters 0.
REQ-021 Reset mid-frame SHALL abort the frame (TxD=1 after the reset edge) and discard buffered data.

Configuration
REQ-022 Macro UART_TX_PARITY_EN: defined -> one parity bit after data, XOR of DATA_BITS data bits, inverted if PARITY_ODD=1.
REQ-023 Undefined -> no PARITY state, frame = 1+DATA_BITS+STOP_BITS bits, PARITY_ODD ignored.

Structure
REQ-024 Package uart_pkg SHALL hold the FSM state enum and bit-width localparams shared with future RX block.
REQ-025 Buffer SHALL be sub-module uart_tx_fifo (sync FIFO, push/pop/count/full/empty); FSM and shifter in top.

Verification (CLK_DIV=4 for all)
REQ-026 Write 0xA5, DATA_BITS=8, no parity -> TxD: 0,1,0,1,0,0,1,0,1,1 each 4 cycles; tx_done pulse at cycle 40.
REQ-027 Write 0x3C then 0xC3 back-to-back -> second start bit immediately follows first stop bit, 80 cycles total, two tx_done pulses.
REQ-028 FIFO_DEPTH=4, write 6 bytes continuously during a frame -> in_ready low when count=4, excess writes dropped, 5 frames sent (1 popped + 4).
REQ-029 UART_TX_PARITY_EN, PARITY_ODD=0, write 0x07 -> parity bit 1; PARITY_ODD=1 -> 0; frame 11 bits.
REQ-030 Reset asserted at cycle 10 of a frame with 2 bytes queued -> TxD=1 next cycle, fifo_count=0, no tx_done, busy=0.
REQ-031 DATA_BITS=7, STOP_BITS=2, write 0xFF -> 7 ones sent, bit 7 ignored, stop held 8 cycles.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: FSM state encoding and widths shared by the UART TX and future RX blocks
package uart_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_state_t;
    localparam int BYTE_W    = 8;
    localparam int BIT_CNT_W = 3;
endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous FIFO; pushes when full and pops when empty are ignored
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int W     = BYTE_W,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          do_push, do_pop;

    assign full    = count == CW'(DEPTH);
    assign empty   = count == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/uart_tx_buf.sv
// uart_tx_buf: buffered UART transmitter (FIFO + frame FSM/shifter).
// Define UART_TX_PARITY_EN to append a parity bit after the data bits.
module uart_tx_buf
    import uart_pkg::*;
#(
    parameter int CLK_DIV    = 10416,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 8,
    parameter int PARITY_ODD = 0,
    localparam int CW        = $clog2(FIFO_DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    output logic          in_ready,
    output logic          TxD,
    output logic          busy,
    output logic          tx_done,
    output logic [CW-1:0] fifo_count
);
    localparam int STOP_LEN = CLK_DIV * STOP_BITS;
    localparam int BW       = $clog2(STOP_LEN);
    localparam logic [BW-1:0]        BIT_LAST  = BW'(CLK_DIV - 1);
    localparam logic [BW-1:0]        STOP_LAST = BW'(STOP_LEN - 1);
    localparam logic [BIT_CNT_W-1:0] DATA_LAST = BIT_CNT_W'(DATA_BITS - 1);
    localparam logic [BYTE_W-1:0]    MASK      = BYTE_W'((1 << DATA_BITS) - 1);
`ifdef UART_TX_PARITY_EN
    localparam uart_state_t AFTER_DATA = PARITY;
`else
    localparam uart_state_t AFTER_DATA = STOP;
`endif

    uart_state_t          state, state_n;
    logic [BW-1:0]        baud;
    logic [BIT_CNT_W-1:0] bit_cnt;
    logic [BYTE_W-1:0]    shifter, head;
    logic                 parity, pop, full, empty, bit_end, stop_end;

    uart_tx_fifo #(.DEPTH(FIFO_DEPTH), .W(BYTE_W)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (in_valid),
        .pop   (pop),
        .din   (in_data),
        .dout  (head),
        .count (fifo_count),
        .full  (full),
        .empty (empty)
    );

    assign in_ready = !full;
    assign busy     = (state != IDLE) || !empty;
    assign bit_end  = baud == BIT_LAST;
    assign stop_end = baud == STOP_LAST;

    always_comb begin
        state_n = state;
        pop     = 1'b0;
        tx_done = (state == STOP) && stop_end;
        TxD     = (state == START) ? 1'b0 :
                  (state == DATA)  ? shifter[0] :
                  (state == PARITY) ? parity : 1'b1;
        case (state)
            IDLE:    begin pop = !empty; state_n = empty ? IDLE : START; end
            START:   if (bit_end) state_n = DATA;
            DATA:    if (bit_end && bit_cnt == DATA_LAST) state_n = AFTER_DATA;
            PARITY:  if (bit_end) state_n = STOP;
            // back-to-back frames: pop on the last stop cycle so no idle gap appears
            STOP:    if (stop_end) begin pop = !empty; state_n = empty ? IDLE : START; end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            baud    <= '0;
            bit_cnt <= '0;
            shifter <= '0;
            parity  <= 1'b0;
        end else begin
            state <= state_n;
            baud  <= (state == IDLE || state_n != state || (state == DATA && bit_end)) ? '0 : baud + BW'(1);
            if (pop) begin
                shifter <= head & MASK;
                parity  <= (^(head & MASK)) ^ PARITY_ODD[0];
                bit_cnt <= '0;
            end else if (state == DATA && bit_end) begin
                shifter <= shifter >> 1;
                bit_cnt <= bit_cnt + BIT_CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_buf.sv
// tb_uart_tx_buf: two configurations checked every cycle against a frame-level model plus literal vectors
module tb_uart_tx_buf;
    localparam int CD = 4;
`ifdef UART_TX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int F0 = (1 + 8 + PB + 1) * CD;
    localparam int F1 = (1 + 7 + PB + 2) * CD;

    logic       clk = 0, reset = 1, in_valid = 0;
    logic [7:0] in_data = 0;
    logic       txd [2], tx_done [2], busy [2], in_ready [2];
    logic [3:0] cnt [2];
    int         nvec = 0, nerr = 0;

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : u
        localparam int DB  = (g == 0) ? 8 : 7;
        localparam int SB  = (g == 0) ? 1 : 2;
        localparam int DEP = (g == 0) ? 4 : 8;
        localparam int CW  = $clog2(DEP) + 1;
        logic [CW-1:0] c;

        uart_tx_buf #(.CLK_DIV(CD), .DATA_BITS(DB), .STOP_BITS(SB), .FIFO_DEPTH(DEP), .PARITY_ODD(g)) dut (
            .clk        (clk),
            .reset      (reset),
            .in_valid   (in_valid),
            .in_data    (in_data),
            .in_ready   (in_ready[g]),
            .TxD        (txd[g]),
            .busy       (busy[g]),
            .tx_done    (tx_done[g]),
            .fifo_count (c)
        );
        assign cnt[g] = 4'(c);

        // model: queue of bytes plus the line level of the frame currently on the wire
        logic [7:0] q [$];
        bit         lvl [16];
        int         nbits = 0, pos = 0;
        bit         active = 0, live = 0;

        always @(posedge clk) begin
            logic [7:0] b;
            bit full, take;
            int n;
            live = 1;
            if (reset) begin
                q.delete();
                active = 0;
                pos = 0;
            end else begin
                full = q.size() == DEP;
                take = 0;
                if (active) begin
                    pos++;
                    if (pos == nbits * CD) begin
                        active = 0;
                        take = q.size() != 0;
                    end
                end else take = q.size() != 0;
                if (take) begin
                    b = q.pop_front() & 8'((1 << DB) - 1);
                    lvl[0] = 0;
                    for (int i = 0; i < DB; i++) lvl[1 + i] = b[i];
                    n = 1 + DB;
`ifdef UART_TX_PARITY_EN
                    lvl[n] = (^b) ^ g[0];
                    n++;
`endif
                    for (int s = 0; s < SB; s++) begin lvl[n] = 1; n++; end
                    nbits = n;
                    active = 1;
                    pos = 0;
                end
                if (in_valid && !full) q.push_back(in_data);
            end
        end

        always @(negedge clk) begin
            if (live) begin
                chk($sformatf("u%0d.TxD", g), txd[g], active ? lvl[pos / CD] : 1'b1);
                chk($sformatf("u%0d.tx_done", g), tx_done[g], active && pos == nbits * CD - 1);
                chk($sformatf("u%0d.busy", g), busy[g], active || q.size() != 0);
                chk($sformatf("u%0d.fifo_count", g), cnt[g], q.size());
                chk($sformatf("u%0d.in_ready", g), in_ready[g], q.size() != DEP);
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [7:0] d);
        in_valid = 1;
        in_data = d;
        tick();
        in_valid = 0;
    endtask

    task automatic wait_idle();
        int k = 0;
        while ((busy[0] || busy[1]) && k < 3000) begin tick(); k++; end
        if (k == 3000) chk("idle_timeout", {busy[0], busy[1]}, 0);
    endtask

    initial begin
        logic [10:0] seq;
        int pulses;
        tick(3);
        chk("rst.TxD", txd[0], 1);
        chk("rst.busy", busy[0], 0);
        chk("rst.count", cnt[0], 0);
        chk("rst.in_ready", in_ready[0], 1);
        chk("rst.tx_done", tx_done[0], 0);
        reset = 0;
        tick(2);

        // 0xA5: start, 1,0,1,0,0,1,0,1, [parity 0], stop
`ifdef UART_TX_PARITY_EN
        seq = 11'b10100101010;
`else
        seq = 11'b01101001010;
`endif
        wr(8'hA5);
        chk("a5.idle_before", txd[0], 1);
        for (int k = 0; k < F0; k++) begin
            tick();
            chk($sformatf("a5.bit%0d", k / CD), txd[0], seq[k / CD]);
            if (k == F0 - 1) chk("a5.tx_done", tx_done[0], 1);
        end
        tick();
        chk("a5.busy_after", busy[0], 0);
        wait_idle();

        // back-to-back frames: second start directly after first stop
        in_valid = 1; in_data = 8'h3C; tick();
        in_data = 8'hC3; tick();
        in_valid = 0;
        pulses = 0;
        for (int k = 0; k < 2 * F0; k++) begin
            if (k == F0 - 1) chk("b2b.stop1", txd[0], 1);
            if (k == F0) chk("b2b.start2", txd[0], 0);
            pulses += int'(tx_done[0]);
            tick();
        end
        chk("b2b.pulses", pulses, 2);
        chk("b2b.busy_after", busy[0], 0);
        wait_idle();

        // overflow of the depth-4 buffer during a frame
        in_valid = 1;
        for (int i = 0; i < 6; i++) begin in_data = 8'h10 + 8'(i); tick(); end
        in_valid = 0;
        chk("ovf.count", cnt[0], 4);
        chk("ovf.in_ready", in_ready[0], 0);
        pulses = 0;
        for (int k = 0; k < 3000 && (busy[0] || busy[1]); k++) begin
            pulses += int'(tx_done[0]);
            tick();
        end
        chk("ovf.frames", pulses, 5);

        // sustained writes straddling full/pop boundaries
        in_valid = 1;
        for (int k = 0; k < 100; k++) begin in_data = 8'(k * 37 + 5); tick(); end
        in_valid = 0;
        wait_idle();

        // reset mid-frame with two bytes queued
        in_valid = 1; in_data = 8'h11; tick();
        in_data = 8'h22; tick();
        in_data = 8'h33; tick();
        in_valid = 0;
        chk("rmf.queued", cnt[0], 2);
        tick(8);
        reset = 1;
        tick();
        reset = 0;
        chk("rmf.TxD", txd[0], 1);
        chk("rmf.count", cnt[0], 0);
        chk("rmf.busy", busy[0], 0);
        chk("rmf.tx_done", tx_done[0], 0);
        pulses = 0;
        for (int k = 0; k < 60; k++) begin pulses += int'(tx_done[0]) + int'(tx_done[1]); tick(); end
        chk("rmf.no_done", pulses, 0);
        chk("rmf.still_idle", busy[0], 0);

        // 7 data bits, 2 stop bits
        wr(8'hFF);
        for (int k = 0; k < F1; k++) begin
            tick();
            chk("d7ff.TxD", txd[1], (k < CD || (PB == 1 && k / CD == 8)) ? 0 : 1);
            if (k == F1 - 2 * CD) chk("d7ff.stop_entry", tx_done[1], 0);
            if (k == F1 - 1) chk("d7ff.tx_done", tx_done[1], 1);
        end
        wait_idle();
        wr(8'h80);
        for (int k = 0; k < F1; k++) begin
            tick();
            chk("d780.TxD", txd[1], (k < 8 * CD) ? 0 : 1);
        end
        wait_idle();

        // parity bit position: even on u0, odd on u1 (stop level without parity)
        wr(8'h07);
        tick(9 * CD + 1);
        chk("p07.u1_bit8", txd[1], PB == 1 ? 0 : 1);
        tick(CD);
        chk("p07.u0_bit9", txd[0], 1);
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
